// File: rtl/registers_bank_if.sv
// Bundles the register-file read/write ports and the dump handshake between
// the pipeline/debug unit (master) and the register bank (slave).
interface registers_bank_if #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 5
);
    logic               enable_i;
    logic [NB_ADDR-1:0] rs_addr_i;
    logic [NB_ADDR-1:0] rt_addr_i;
    logic [NB_DATA-1:0] rs_data_o;
    logic [NB_DATA-1:0] rt_data_o;
    logic               reg_write_i;
    logic [NB_ADDR-1:0] write_addr_i;
    logic [NB_DATA-1:0] write_data_i;
    logic               dump_start_i;
    logic               dump_ready_i;
    logic               dump_valid_o;
    logic [NB_ADDR-1:0] dump_addr_o;
    logic [NB_DATA-1:0] dump_data_o;
    logic               dump_last_o;
    logic               dump_busy_o;
    logic               dump_done_o;

    modport master (
        output enable_i, rs_addr_i, rt_addr_i, reg_write_i, write_addr_i,
               write_data_i, dump_start_i, dump_ready_i,
        input  rs_data_o, rt_data_o, dump_valid_o, dump_addr_o, dump_data_o,
               dump_last_o, dump_busy_o, dump_done_o
    );

    modport slave (
        input  enable_i, rs_addr_i, rt_addr_i, reg_write_i, write_addr_i,
               write_data_i, dump_start_i, dump_ready_i,
        output rs_data_o, rt_data_o, dump_valid_o, dump_addr_o, dump_data_o,
               dump_last_o, dump_busy_o, dump_done_o
    );
endinterface

// File: rtl/registers_bank.sv
// MIPS register file: 32 x 32-bit, $zero hardwired, two bypassed read ports,
// one write port, and a valid/ready sequencer that streams every register out.
module registers_bank #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 5,
    parameter int N_REGS  = 2**NB_ADDR
) (
    input  logic           clock_i,
    input  logic           reset_i,
    registers_bank_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_DONE
    } dump_state_t;

    localparam logic [NB_ADDR-1:0] LAST_IDX = NB_ADDR'(N_REGS - 1);

    logic [NB_DATA-1:0] r_regs [N_REGS];
    dump_state_t        r_state;
    dump_state_t        w_state_next;
    logic [NB_ADDR-1:0] r_index;
    logic [NB_ADDR-1:0] w_index_next;

    logic               w_write_en;
    logic               w_bypass_en;
    logic [NB_DATA-1:0] w_rs_data;
    logic [NB_DATA-1:0] w_rt_data;
    logic               w_dump_valid;
    logic               w_dump_last;
    logic               w_dump_busy;
    logic               w_dump_done;

    assign w_bypass_en = !reset_i && bus.enable_i && bus.reg_write_i;
    assign w_write_en  = w_bypass_en && (bus.write_addr_i != '0);

    // NOTE: the array is cleared on reset because the architectural contract
    // is "all registers read 0 after reset"; this keeps it in flops, not a RAM.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int i = 0; i < N_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_write_en) begin
            r_regs[bus.write_addr_i] <= bus.write_data_i;
        end
    end

    // NOTE: every combinational output gets its default first, so no path
    // through the if-chain leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_rs_data = r_regs[bus.rs_addr_i];
        if (reset_i || bus.rs_addr_i == '0) begin
            w_rs_data = '0;
        end else if (w_bypass_en && bus.write_addr_i == bus.rs_addr_i) begin
            w_rs_data = bus.write_data_i;
        end
    end

    always_comb begin
        w_rt_data = r_regs[bus.rt_addr_i];
        if (reset_i || bus.rt_addr_i == '0) begin
            w_rt_data = '0;
        end else if (w_bypass_en && bus.write_addr_i == bus.rt_addr_i) begin
            w_rt_data = bus.write_data_i;
        end
    end

    // NOTE: state flops use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
            r_index <= '0;
        end else begin
            r_state <= w_state_next;
            r_index <= w_index_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_index_next = r_index;
        w_dump_valid = 1'b0;
        w_dump_last  = 1'b0;
        w_dump_busy  = 1'b0;
        w_dump_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.dump_start_i) begin
                    w_state_next = ST_SEND;
                    w_index_next = '0;
                end
            end
            ST_SEND: begin
                w_dump_valid = 1'b1;
                w_dump_busy  = 1'b1;
                w_dump_last  = (r_index == LAST_IDX);
                if (bus.dump_ready_i) begin
                    if (r_index == LAST_IDX) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_index_next = r_index + NB_ADDR'(1);
                    end
                end
            end
            ST_DONE: begin
                w_dump_busy  = 1'b1;
                w_dump_done  = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.rs_data_o    = w_rs_data;
    assign bus.rt_data_o    = w_rt_data;
    assign bus.dump_valid_o = w_dump_valid;
    assign bus.dump_last_o  = w_dump_last;
    assign bus.dump_busy_o  = w_dump_busy;
    assign bus.dump_done_o  = w_dump_done;
    // Beats carry the live array value, so a write landing mid-dump is visible.
    assign bus.dump_addr_o  = w_dump_valid ? r_index : '0;
    assign bus.dump_data_o  = w_dump_valid ? r_regs[r_index] : '0;
endmodule

// File: doc/registers_bank.md
# registers_bank

MIPS general-purpose register file: the consumer of the write-back value produced at the end of the pipeline, and the source of operands for the decode stage. It holds 32 × 32-bit registers with $zero hardwired to 0, two combinational read ports with same-cycle write-back bypass, and one write port driven by the write-back stage. A dump sequencer streams all registers to the debug unit over a valid/ready handshake.

## Interface
Parameters:
- NB_DATA, 32, register width
- NB_ADDR, 5, register address width
- N_REGS, 32, number of registers (2**NB_ADDR)

Ports:
- clock_i  in  1  single clock; all state updates on the rising edge
- reset_i  in  1  synchronous, active-high reset
- enable_i  in  1  pipeline step enable from the debug unit; gates writes
- rs_addr_i  in  NB_ADDR  read port A address
- rt_addr_i  in  NB_ADDR  read port B address
- rs_data_o  out  NB_DATA  read port A data
- rt_data_o  out  NB_DATA  read port B data
- reg_write_i  in  1  write request from write-back
- write_addr_i  in  NB_ADDR  destination register
- write_data_i  in  NB_DATA  write-back data (mux output of the WB stage)
- dump_start_i  in  1  request a full register dump
- dump_ready_i  in  1  debug unit can accept a beat
- dump_valid_o  out  1  dump beat valid
- dump_addr_o  out  NB_ADDR  index of current beat
- dump_data_o  out  NB_DATA  contents of register dump_addr_o
- dump_last_o  out  1  current beat is register 31
- dump_busy_o  out  1  sequencer not IDLE
- dump_done_o  out  1  one-cycle pulse after the final handshake

## Operation
- Write: on rising edge, if !reset_i && enable_i && reg_write_i && write_addr_i != 0, regs[write_addr_i] <= write_data_i. Writes to address 0 discarded.
- Read (combinational): address 0 → 0. Else if enable_i && reg_write_i && write_addr_i == read address → write_data_i (bypass). Else regs[address]. Both ports independent; rs == rt both bypass.
- Reset: all registers cleared to 0; bypass suppressed while reset_i high.
- Dump FSM states: IDLE, SEND, DONE.
  - IDLE: dump_start_i=1 → SEND, index <= 0. Otherwise stay.
  - SEND: dump_valid_o=1, dump_addr_o=index, dump_data_o=regs[index] (array value, no bypass), dump_last_o=(index==31). On dump_valid_o && dump_ready_i: if index==31 → DONE, else index <= index+1. No ready → hold beat unchanged.
  - DONE: dump_done_o=1 for this cycle only, → IDLE.
  - dump_start_i ignored outside IDLE.
- Writes during a dump are permitted; a beat reflects array content in the cycle of its handshake (no snapshot). Debug unit normally holds enable_i=0 while dumping.
- Dump does not affect read ports or writes.

## Timing
- Reset values: all registers 0; FSM IDLE; index 0; dump_valid_o, dump_last_o, dump_busy_o, dump_done_o = 0; dump_addr_o = 0; dump_data_o = 0; rs_data_o/rt_data_o = 0.
- Write latency: value in array after the capturing edge; visible on read ports in the same cycle via bypass.
- Dump: start sampled at edge t → dump_valid_o high from cycle t+1. With dump_ready_i held high: 32 beats on cycles t+1..t+32, dump_done_o in cycle t+33, busy low from t+34.
- dump_busy_o high in SEND and DONE.
- reset_i mid-dump: next cycle IDLE, valid/last/done low, index 0; no partial resume.
- dump_start_i coincident with reset_i: reset wins.

## Test plan
- Reset, then read all 32 addresses on rs and rt → all 0; write reg 0 with 0xDEADBEEF → reads 0 next cycle and via bypass.
- enable_i=1, write reg 5 = 0x12345678, rs_addr=5 same cycle → rs_data_o=0x12345678 (bypass); next cycle with reg_write_i=0 → still 0x12345678; repeat with enable_i=0 → no write, no bypass.
- Write reg 7 = 0xA5A5A5A5 while rs=rt=7 → both ports 0xA5A5A5A5 same cycle.
- Load reg n = n×0x01010101, dump with ready always high → 32 beats addr 0..31 with matching data, last only on addr 31, done pulse at t+33.
- Dump with ready toggling 1/0 each cycle → beat held during ready=0, exactly 32 handshakes, no skipped/duplicated addresses; dump_start_i pulsed mid-dump ignored.
- Assert reset_i at beat 10 → valid low and busy low next cycle, registers 0; new dump starts at addr 0.
